neuron_controller: RTL
======================

Name: neuron_controller

Overview:
Sequencer for one neuron datapath (8-bit sign-magnitude multiply, 16-bit accumulate, activation).
- Clears the accumulator, then walks an input/weight index over a requested vector length, pulsing accumulator load once per accepted element.
- After the last element it captures the activated result and signals completion.
- Sits between the layer-level scheduler (start/done) and the datapath plus its input/weight memories (idx, in_valid).

Parameters:
- N, 16, maximum vector length; requested lengths above N saturate to N.
- IDX_W, 16, width of the idx bus and of the len input.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a neuron evaluation; sampled only in IDLE.
- len  input  IDX_W  number of input/weight pairs; latched when start is accepted.
- in_valid  input  1  memory/stream has valid in/w for the current idx.
- res  input  16  activation output from the datapath.
- reg_rst  output  1  synchronous accumulator clear to the datapath.
- ld  output  1  accumulator load enable to the datapath.
- idx  output  IDX_W  current element index to the input/weight memories.
- busy  output  1  high from CLEAR through SETTLE.
- done  output  1  one-cycle completion pulse.
- result  output  16  registered activated result; holds until the next capture.

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE; reg_rst=0, ld=0, idx=0, busy=0, done=0, result=0, latched length=0.
  - Reset mid-operation aborts immediately; the accumulator is not touched, and the next run's CLEAR handles it.
- States: IDLE, CLEAR, ACC, SETTLE, DONE. Outputs are decoded from state and registered counters; no combinational path from start to outputs.
- IDLE:
  - All strobes low; idx=0.
  - start=1 latches L = min(len, N) and moves to CLEAR.
- CLEAR (exactly 1 cycle):
  - reg_rst=1, busy=1, idx=0.
  - Next state is ACC if L>0, else SETTLE.
- ACC:
  - busy=1; ld = in_valid (combinational AND with state); idx = element counter.
  - Edge with in_valid=1: element idx is accumulated. If idx==L-1, go to SETTLE with idx held; else idx+1.
  - Edge with in_valid=0: idx and state hold; no load occurs, so stalls are unbounded.
- SETTLE (exactly 1 cycle):
  - ld=0, busy=1; the accumulator holds its final value and res is valid.
  - At the end of the cycle, result <= res. Next state is DONE.
- DONE (exactly 1 cycle):
  - done=1, busy=0.
  - start is ignored here. Next state is IDLE, so back-to-back runs lose one idle cycle.
- start while busy or in DONE: ignored, no queueing. len changes after acceptance have no effect.
- Latency: start sampled at edge E0, with in_valid held high, gives done high in the cycle after edge E0+L+2. Each in_valid=0 cycle during ACC adds one cycle.
- Exactly L ld cycles per run. idx visits 0..L-1 in order, never reaches L, and never wraps.
- L=0: no ld pulses. result = res observed with the accumulator cleared, i.e. act(0).
- len > N: L=N and idx stops at N-1.

Test Plan:
- Basic run: len=4, in_valid=1, datapath with in=3, w=2 each element → reg_rst one cycle; ld on 4 consecutive cycles with idx 0,1,2,3; accumulator=24; done 6 cycles after the start edge; result = res sampled in SETTLE (act(24)).
- Stalls: len=3, in_valid pattern 1,0,0,1,0,1 → idx holds during each low; ld only on high cycles (3 total); done 3 cycles later than the no-stall case.
- Zero length: len=0, start → CLEAR, SETTLE, DONE; no ld; done after 2 cycles; result=act(0).
- Saturation: len=40 with N=16 → 16 ld pulses, idx max 15, done after 18 cycles.
- Ignored start and back-to-back: pulse start mid-ACC and in DONE → no effect on the current run; start held continuously → second run's CLEAR begins one cycle after DONE; result from run 1 held until run 2's SETTLE.
- Async reset: drop rst_n mid-ACC at idx=5, off the clock edge → ld, busy, idx, result go to 0 immediately; after release, a fresh len=2 run completes with correct result.

Source files
------------

// File: rtl/neuron_controller.sv
// Sequencer for a single neuron datapath: clears the accumulator, steps the
// input/weight index over the requested length, then captures the activated result.
module neuron_controller #(
  parameter int N     = 16,
  parameter int IDX_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [IDX_W-1:0] len,
  input  logic             in_valid,
  input  logic [15:0]      res,
  output logic             reg_rst,
  output logic             ld,
  output logic [IDX_W-1:0] idx,
  output logic             busy,
  output logic             done,
  output logic [15:0]      result
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_ACC    = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [IDX_W-1:0] N_MAX    = IDX_W'(N);
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  logic [2:0]       state_r;
  logic [2:0]       state_s;
  logic [IDX_W-1:0] idx_r;
  logic [IDX_W-1:0] idx_s;
  logic [IDX_W-1:0] len_r;
  logic [IDX_W-1:0] len_sat_s;
  logic [15:0]      result_r;
  logic             reg_rst_r;
  logic             busy_r;
  logic             done_r;

  assign len_sat_s = (len > N_MAX) ? N_MAX : len;

  // Next-state and element-index decode
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    case (state_r)
      S_IDLE: begin
        idx_s = IDX_ZERO;
        if (start) begin
          state_s = S_CLEAR;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_CLEAR: begin
        idx_s = IDX_ZERO;
        if (len_r == IDX_ZERO) begin
          state_s = S_SETTLE;
        end else begin
          state_s = S_ACC;
        end
      end
      S_ACC: begin
        // The last element leaves idx parked at L-1 so it never reaches L.
        if (in_valid) begin
          if (idx_r == (len_r - IDX_ONE)) begin
            state_s = S_SETTLE;
            idx_s   = idx_r;
          end else begin
            state_s = S_ACC;
            idx_s   = idx_r + IDX_ONE;
          end
        end else begin
          state_s = S_ACC;
          idx_s   = idx_r;
        end
      end
      S_SETTLE: begin
        state_s = S_DONE;
        idx_s   = idx_r;
      end
      S_DONE: begin
        state_s = S_IDLE;
        idx_s   = IDX_ZERO;
      end
      default: begin
        state_s = S_IDLE;
        idx_s   = IDX_ZERO;
      end
    endcase
  end

  // State, counters, latched length, result capture and registered strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      idx_r     <= IDX_ZERO;
      len_r     <= IDX_ZERO;
      result_r  <= 16'd0;
      reg_rst_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      idx_r     <= idx_s;
      reg_rst_r <= (state_s == S_CLEAR);
      busy_r    <= (state_s == S_CLEAR) || (state_s == S_ACC) || (state_s == S_SETTLE);
      done_r    <= (state_s == S_DONE);
      if ((state_r == S_IDLE) && start) begin
        len_r <= len_sat_s;
      end else begin
        len_r <= len_r;
      end
      if (state_r == S_SETTLE) begin
        result_r <= res;
      end else begin
        result_r <= result_r;
      end
    end
  end

  assign ld      = (state_r == S_ACC) && in_valid;
  assign reg_rst = reg_rst_r;
  assign idx     = idx_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign result  = result_r;

endmodule
